// File: rtl/fd_de_pipeline_regs.sv
// fd_de_pipeline_regs: PC, F/D and D/E pipeline registers honouring StallF/StallD/FlushE/PCSrcD, plus saturating stall/bubble counters (Clk/Reset, hazard controls, F-stage inputs -> PCF/InstrD/PCPlus4D, D-stage fields -> E outputs, StallCount/BubbleCount)
module fd_de_pipeline_regs #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushE,
  input  logic             PCSrcD,
  input  logic [WIDTH-1:0] PCNextF,
  input  logic [WIDTH-1:0] InstrF,
  input  logic [WIDTH-1:0] PCPlus4F,
  output logic [WIDTH-1:0] PCF,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PCPlus4D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic             ALUSrcD,
  input  logic             RegDstD,
  input  logic [2:0]       ALUControlD,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] SignImmD,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RdD,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             MemWriteE,
  output logic             ALUSrcE,
  output logic             RegDstE,
  output logic [2:0]       ALUControlE,
  output logic [WIDTH-1:0] RD1E,
  output logic [WIDTH-1:0] RD2E,
  output logic [WIDTH-1:0] SignImmE,
  output logic [4:0]       RsE,
  output logic [4:0]       RtE,
  output logic [4:0]       RdE,
  output logic [15:0]      StallCount,
  output logic [15:0]      BubbleCount
);
  localparam int DEW = 3 * WIDTH + 23;
  logic [WIDTH-1:0] pcf_q, pcf_d, fd_instr_q, fd_instr_d, fd_pcp4_q, fd_pcp4_d;
  logic [DEW-1:0] de_q, de_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
  logic [16:0] bubble_sum;
  always_comb begin
    pcf_d = StallF ? pcf_q : PCNextF;
    fd_instr_d = StallD ? fd_instr_q : PCSrcD ? '0 : InstrF;
    fd_pcp4_d = StallD ? fd_pcp4_q : PCSrcD ? '0 : PCPlus4F;
    de_d = FlushE ? '0 : {RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD,
                          RD1D, RD2D, SignImmD, RsD, RtD, RdD};
    stall_cnt_d = (StallD && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    bubble_sum = {1'b0, bubble_cnt_q} + 17'(FlushE) + 17'(PCSrcD & ~StallD);
    bubble_cnt_d = bubble_sum[16] ? 16'hFFFF : bubble_sum[15:0];
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pcf_q <= RESET_PC;
      fd_instr_q <= '0;
      fd_pcp4_q <= '0;
      de_q <= '0;
      stall_cnt_q <= '0;
      bubble_cnt_q <= '0;
    end else begin
      pcf_q <= pcf_d;
      fd_instr_q <= fd_instr_d;
      fd_pcp4_q <= fd_pcp4_d;
      de_q <= de_d;
      stall_cnt_q <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
  assign PCF = pcf_q;
  assign InstrD = fd_instr_q;
  assign PCPlus4D = fd_pcp4_q;
  assign {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
          RD1E, RD2E, SignImmE, RsE, RtE, RdE} = de_q;
  assign StallCount = stall_cnt_q;
  assign BubbleCount = bubble_cnt_q;
endmodule

// File: tb/tb_fd_de_pipeline_regs.sv
// tb_fd_de_pipeline_regs: directed scoreboard bench for fd_de_pipeline_regs
module tb_fd_de_pipeline_regs;
  logic Clk = 1'b0, Reset = 1'b1;
  logic StallF = 0, StallD = 0, FlushE = 0, PCSrcD = 0;
  logic [31:0] PCNextF = 0, InstrF = 0, PCPlus4F = 0, PCF, InstrD, PCPlus4D;
  logic RegWriteD = 0, MemtoRegD = 0, MemWriteD = 0, ALUSrcD = 0, RegDstD = 0;
  logic [2:0] ALUControlD = 0, ALUControlE;
  logic [31:0] RD1D = 0, RD2D = 0, SignImmD = 0, RD1E, RD2E, SignImmE;
  logic [4:0] RsD = 0, RtD = 0, RdD = 0, RsE, RtE, RdE;
  logic RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [15:0] StallCount, BubbleCount;
  int errors = 0, checks = 0;

  typedef struct packed {
    logic [31:0] pcf, instrd, pcp4d;
    logic [4:0]  ctl;
    logic [2:0]  aluc;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [15:0] sc, bc;
  } st_t;
  st_t m, sb[$];

  localparam logic [31:0] IA = 32'hA9CB5E63, IB = 32'h5F3172C4, IC = 32'hE4D2B896, ID = 32'h3B6E9D17;
  localparam logic [31:0] IBR = 32'h8C010004;

  fd_de_pipeline_regs dut (
    .Clk(Clk), .Reset(Reset), .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .PCSrcD(PCSrcD),
    .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F), .PCF(PCF), .InstrD(InstrD),
    .PCPlus4D(PCPlus4D), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D),
    .SignImmD(SignImmD), .RsD(RsD), .RtD(RtD), .RdD(RdD), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .RsE(RsE),
    .RtE(RtE), .RdE(RdE), .StallCount(StallCount), .BubbleCount(BubbleCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input st_t e);
    chk({tag, ".PCF"}, PCF, e.pcf);
    chk({tag, ".InstrD"}, InstrD, e.instrd);
    chk({tag, ".PCPlus4D"}, PCPlus4D, e.pcp4d);
    chk({tag, ".ctlE"}, {27'd0, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE}, {27'd0, e.ctl});
    chk({tag, ".ALUControlE"}, {29'd0, ALUControlE}, {29'd0, e.aluc});
    chk({tag, ".RD1E"}, RD1E, e.rd1);
    chk({tag, ".RD2E"}, RD2E, e.rd2);
    chk({tag, ".SignImmE"}, SignImmE, e.imm);
    chk({tag, ".RsE"}, {27'd0, RsE}, {27'd0, e.rs});
    chk({tag, ".RtE"}, {27'd0, RtE}, {27'd0, e.rt});
    chk({tag, ".RdE"}, {27'd0, RdE}, {27'd0, e.rd});
    chk({tag, ".StallCount"}, {16'd0, StallCount}, {16'd0, e.sc});
    chk({tag, ".BubbleCount"}, {16'd0, BubbleCount}, {16'd0, e.bc});
  endtask

  // D-stage inputs are derived from the instruction the model says is in D
  task automatic step(input string tag, input logic stf, std, fle, pcs, input logic [31:0] instr,
                      input bit chk_on);
    st_t e;
    int b;
    StallF = stf; StallD = std; FlushE = fle; PCSrcD = pcs;
    PCNextF = m.pcf + 32'd4; InstrF = instr; PCPlus4F = m.pcf + 32'd4;
    {RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD} = m.instrd[31:27];
    ALUControlD = m.instrd[2:0];
    RD1D = m.instrd ^ 32'hA5A5A5A5; RD2D = ~m.instrd;
    SignImmD = {{16{m.instrd[15]}}, m.instrd[15:0]};
    RsD = m.instrd[25:21]; RtD = m.instrd[20:16]; RdD = m.instrd[15:11];
    e = m;
    if (!stf) e.pcf = m.pcf + 32'd4;
    if (!std) begin
      e.instrd = pcs ? 32'd0 : instr;
      e.pcp4d = pcs ? 32'd0 : m.pcf + 32'd4;
    end
    e.ctl = fle ? 5'd0 : m.instrd[31:27];
    e.aluc = fle ? 3'd0 : m.instrd[2:0];
    e.rd1 = fle ? 32'd0 : RD1D;
    e.rd2 = fle ? 32'd0 : RD2D;
    e.imm = fle ? 32'd0 : SignImmD;
    e.rs = fle ? 5'd0 : RsD;
    e.rt = fle ? 5'd0 : RtD;
    e.rd = fle ? 5'd0 : RdD;
    e.sc = (std && m.sc != 16'hFFFF) ? m.sc + 16'd1 : m.sc;
    b = int'(m.bc) + int'(fle) + int'(pcs && !std);
    e.bc = (b > 65535) ? 16'hFFFF : 16'(b);
    sb.push_back(e);
    m = e;
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    if (chk_on) check_all(tag, e);
  endtask

  task automatic do_reset(input string tag);
    #2 Reset = 1'b1;
    #1;
    m = '0;
    check_all(tag, m);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    m = '0;
    #1 check_all("reset0", m);
    @(negedge Clk);
    Reset = 1'b0;
    step("lineA", 0, 0, 0, 0, IA, 1);
    chk("lineA.InstrD_is_A", InstrD, IA);
    step("lineB", 0, 0, 0, 0, IB, 1);
    chk("lineB.RsE_is_A", {27'd0, RsE}, {27'd0, IA[25:21]});
    step("loaduse", 1, 1, 1, 0, IC, 1);
    chk("loaduse.PCF_hold", PCF, 32'd8);
    chk("loaduse.InstrD_hold", InstrD, IB);
    chk("loaduse.RegWriteE", {31'd0, RegWriteE}, 32'd0);
    chk("loaduse.counts", {StallCount, BubbleCount}, {16'd1, 16'd1});
    step("after_lu", 0, 0, 0, 0, IC, 1);
    chk("after_lu.RsE_is_B", {27'd0, RsE}, {27'd0, IB[25:21]});
    chk("after_lu.PCF", PCF, 32'd12);
    step("squash", 0, 0, 0, 1, IBR, 1);
    chk("squash.InstrD", InstrD, 32'd0);
    chk("squash.BubbleCount", {16'd0, BubbleCount}, 32'd2);
    step("lineD", 0, 0, 0, 0, ID, 1);
    step("stall_vs_squash", 1, 1, 0, 1, IA, 1);
    chk("stall_vs_squash.InstrD", InstrD, ID);
    chk("stall_vs_squash.BubbleCount", {16'd0, BubbleCount}, 32'd2);
    step("resume", 0, 0, 0, 0, IB, 1);
    step("stall1", 1, 1, 0, 0, IC, 1);
    step("stall2", 1, 1, 0, 0, IC, 1);
    do_reset("reset_mid_stall");
    step("refillA", 0, 0, 0, 0, IA, 1);
    step("refillB", 0, 0, 0, 0, IB, 1);
    chk("refill.PCF", PCF, 32'd8);
    chk("refill.RsE_is_A", {27'd0, RsE}, {27'd0, IA[25:21]});
    do_reset("reset_pre_sat");
    for (int i = 0; i < 65534; i++) step("bulk", 1, 1, 1, 0, IC, 0);
    chk("sat.pre", {StallCount, BubbleCount}, {16'hFFFE, 16'hFFFE});
    step("sat_double", 0, 0, 1, 1, ID, 1);
    chk("sat_double.BubbleCount", {16'd0, BubbleCount}, 32'h0000FFFF);
    step("sat_stall1", 1, 1, 0, 0, IA, 1);
    step("sat_stall2", 1, 1, 0, 0, IA, 1);
    step("sat_stall3", 1, 1, 1, 0, IA, 1);
    chk("sat.final", {StallCount, BubbleCount}, {16'hFFFF, 16'hFFFF});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
